serial_work_transmit: RTL and testbench



---
 rtl/serial_work_transmit_if.sv | 9 +
 rtl/serial_work_transmit.sv | 102 ++++++++++
 tb/tb_serial_work_transmit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_work_transmit_if.sv
// Byte-level handshake between the work-packet serializer and a UART transmitter.
interface serial_work_transmit_if;
  logic       tx_ready;
  logic       tx_new_byte;
  logic [7:0] tx_byte;

  modport master (input tx_ready, output tx_new_byte, output tx_byte);
  modport slave  (output tx_ready, input tx_new_byte, input tx_byte);
endinterface

// File: rtl/serial_work_transmit.sv
// Serializes the 84-byte work packet (target, data3, data2, data1) MSB first
// through a one-byte strobe/ready handshake to a UART transmitter.
module serial_work_transmit #(
  parameter int unsigned PACKET_BYTES = 84
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   send,
  input  logic                   abort,
  input  logic [31:0]            target,
  input  logic [127:0]           data3,
  input  logic [255:0]           data2,
  input  logic [255:0]           data1,
  serial_work_transmit_if.master tx,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned SHIFT_W = PACKET_BYTES * 8;
  localparam int unsigned CNT_W   = 7;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               new_byte_q, new_byte_d;
  logic [7:0]         byte_q, byte_d;
  logic               done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      count_q    <= '0;
      new_byte_q <= 1'b0;
      byte_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      new_byte_q <= new_byte_d;
      byte_q     <= byte_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; strobe and done are single-cycle so they default low
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    count_d    = count_q;
    new_byte_d = 1'b0;
    byte_d     = byte_q;
    done_d     = 1'b0;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (send && !abort) begin
            shift_d = {target, data3, data2, data1};
            count_d = '0;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (tx.tx_ready) begin
            if (count_q == CNT_W'(PACKET_BYTES)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              new_byte_d = 1'b1;
              byte_d     = shift_q[SHIFT_W-1 -: 8];
              shift_d    = {shift_q[SHIFT_W-9:0], 8'h00};
              count_d    = count_q + CNT_W'(1);
              state_d    = HOLD;
            end
          end
        end
        // One dead cycle lets the UART drop tx_ready before it is looked at again
        HOLD: begin
          state_d = ISSUE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign tx.tx_new_byte = new_byte_q;
  assign tx.tx_byte     = byte_q;
  assign done           = done_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_serial_work_transmit.sv
// Randomized self-checking bench for serial_work_transmit with a simple UART
// handshake model and a receiver-side packet reassembly model.
module tb_serial_work_transmit;

  logic clk = 1'b0;
  logic rst_n;
  logic send, abort;
  logic [31:0]  target;
  logic [127:0] data3;
  logic [255:0] data2, data1;
  logic busy, done;

  always #5 clk = ~clk;

  serial_work_transmit_if tx_if ();

  serial_work_transmit dut (
    .clk     (clk),
    .reset_n (rst_n),
    .send    (send),
    .abort   (abort),
    .target  (target),
    .data3   (data3),
    .data2   (data2),
    .data1   (data1),
    .tx      (tx_if),
    .busy    (busy),
    .done    (done)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation log and UART model; only this process writes these
  logic [7:0] got_q [$];
  int         strobe_cyc [$];
  int         done_cnt = 0, done_cyc = 0, busy_cnt = 0, busy_fall_cyc = 0, rise_cyc = 0;
  logic       busy_prev = 1'b0;
  int         hold_left = 0;
  int         uart_mode = 0;

  always @(negedge clk) begin
    if (tx_if.tx_new_byte === 1'b1) begin
      got_q.push_back(tx_if.tx_byte);
      strobe_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) busy_cnt++;
    if (busy_prev && (busy === 1'b0)) busy_fall_cyc = cyc;
    busy_prev = (busy === 1'b1);
    if (uart_mode == 0) begin
      tx_if.tx_ready = 1'b1;
    end else if (tx_if.tx_new_byte === 1'b1) begin
      tx_if.tx_ready = 1'b0;
      hold_left      = 10;
    end else if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) begin
        tx_if.tx_ready = 1'b1;
        rise_cyc       = cyc;
      end
    end else begin
      tx_if.tx_ready = 1'b1;
    end
  end

  logic [7:0] exp_b [84];

  // Expected byte stream straight from the packet layout: target, data3, data2, data1, MSB first
  function automatic void build_exp(input logic [31:0] t, input logic [127:0] d3,
                                    input logic [255:0] d2, input logic [255:0] d1);
    for (int i = 0; i < 84; i++) begin
      if (i < 4)       exp_b[i] = 8'(t  >> (8 * (3 - i)));
      else if (i < 20) exp_b[i] = 8'(d3 >> (8 * (19 - i)));
      else if (i < 52) exp_b[i] = 8'(d2 >> (8 * (51 - i)));
      else             exp_b[i] = 8'(d1 >> (8 * (83 - i)));
    end
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  task automatic randomize_inputs();
    target = 32'($urandom());
    data3  = {32'($urandom()), 32'($urandom()), 32'($urandom()), 32'($urandom())};
    data2  = rand256();
    data1  = rand256();
  endtask

  task automatic pulse_send(output int s_cyc);
    @(posedge clk);
    #1 send = 1'b1;
    s_cyc = cyc;
    @(posedge clk);
    #1 send = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_strobes(input int base, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (got_q.size() - base >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (tx_if.tx_new_byte !== 1'b0) $display("FAIL reset_new_byte: got %b want 0", tx_if.tx_new_byte); else pass_cnt++;
    chk_cnt++; if (tx_if.tx_byte !== 8'h00) $display("FAIL reset_tx_byte: got %h want 00", tx_if.tx_byte); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_full_packet();
    int base, dbase, s_cyc, bad;
    bit ok;
    logic [671:0] acc;
    uart_mode = 1;
    target = 32'h11223344;
    data3  = 128'h000102030405060708090A0B0C0D0E0F;
    data2  = rand256();
    data1  = rand256();
    build_exp(target, data3, data2, data1);
    base = got_q.size(); dbase = done_cnt;
    pulse_send(s_cyc);
    wait_done(dbase, 2000, ok);
    chk_cnt++; if (!ok) $display("FAIL uart_done_timeout: got no done want done"); else pass_cnt++;
    chk_cnt++; if (got_q.size() - base !== 84) $display("FAIL uart_strobes: got %0d want 84", got_q.size() - base); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 84 && base + i < got_q.size(); i++) if (got_q[base + i] !== exp_b[i]) bad++;
    chk_cnt++; if (bad != 0) $display("FAIL uart_bytes: got %0d wrong bytes want 0", bad); else pass_cnt++;
    chk_cnt++; if (got_q.size() > base && got_q[base] !== 8'h11) $display("FAIL uart_first: got %h want 11", got_q[base]); else if (got_q.size() > base) pass_cnt++;
    chk_cnt++; if (got_q[got_q.size() - 1] !== data1[7:0]) $display("FAIL uart_last: got %h want %h", got_q[got_q.size() - 1], data1[7:0]); else pass_cnt++;
    chk_cnt++; if (done_cnt - dbase !== 1) $display("FAIL uart_done_count: got %0d want 1", done_cnt - dbase); else pass_cnt++;
    chk_cnt++; if (!(done_cyc > rise_cyc)) $display("FAIL uart_done_after_ready: got done %0d ready rise %0d", done_cyc, rise_cyc); else pass_cnt++;
    chk_cnt++; if (busy_fall_cyc !== done_cyc) $display("FAIL uart_busy_fall: got %0d want %0d", busy_fall_cyc, done_cyc); else pass_cnt++;
    // Receiver-side reassembly: shift each byte in from the right
    acc = '0;
    for (int i = base; i < got_q.size(); i++) acc = {acc[663:0], got_q[i]};
    chk_cnt++; if (acc[671:640] !== target) $display("FAIL loop_target: got %h want %h", acc[671:640], target); else pass_cnt++;
    chk_cnt++; if (acc[639:512] !== data3) $display("FAIL loop_data3: got %h want %h", acc[639:512], data3); else pass_cnt++;
    chk_cnt++; if (acc[511:256] !== data2) $display("FAIL loop_data2: got %h want %h", acc[511:256], data2); else pass_cnt++;
    chk_cnt++; if (acc[255:0] !== data1) $display("FAIL loop_data1: got %h want %h", acc[255:0], data1); else pass_cnt++;
  endtask

  task automatic test_ready_high();
    int base, dbase, bbase, s_cyc, bad, last;
    bit ok;
    uart_mode = 0;
    repeat (2) @(posedge clk);
    randomize_inputs();
    build_exp(target, data3, data2, data1);
    base = got_q.size(); dbase = done_cnt; bbase = busy_cnt;
    pulse_send(s_cyc);
    wait_done(dbase, 400, ok);
    chk_cnt++; if (!ok) $display("FAIL fast_done_timeout: got no done want done"); else pass_cnt++;
    chk_cnt++; if (got_q.size() - base !== 84) $display("FAIL fast_strobes: got %0d want 84", got_q.size() - base); else pass_cnt++;
    chk_cnt++; if (strobe_cyc.size() > base && strobe_cyc[base] !== s_cyc + 2) $display("FAIL fast_first_cycle: got %0d want %0d", strobe_cyc[base], s_cyc + 2); else if (strobe_cyc.size() > base) pass_cnt++;
    bad = 0;
    for (int i = base + 1; i < strobe_cyc.size(); i++) if (strobe_cyc[i] - strobe_cyc[i - 1] != 2) bad++;
    chk_cnt++; if (bad != 0) $display("FAIL fast_spacing: got %0d bad gaps want 0", bad); else pass_cnt++;
    last = strobe_cyc[strobe_cyc.size() - 1];
    chk_cnt++; if (done_cyc !== last + 2) $display("FAIL fast_done_cycle: got %0d want %0d", done_cyc, last + 2); else pass_cnt++;
    chk_cnt++; if (busy_cnt - bbase !== 169) $display("FAIL fast_busy_len: got %0d want 169", busy_cnt - bbase); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 84 && base + i < got_q.size(); i++) if (got_q[base + i] !== exp_b[i]) bad++;
    chk_cnt++; if (bad != 0) $display("FAIL fast_bytes: got %0d wrong bytes want 0", bad); else pass_cnt++;
  endtask

  task automatic test_send_while_busy();
    int base, dbase, s_cyc, bad;
    bit ok;
    uart_mode = 0;
    randomize_inputs();
    build_exp(target, data3, data2, data1);
    base = got_q.size(); dbase = done_cnt;
    pulse_send(s_cyc);
    wait_strobes(base, 30, 200, ok);
    chk_cnt++; if (!ok) $display("FAIL busy_send_reach30: got %0d strobes want 30", got_q.size() - base); else pass_cnt++;
    randomize_inputs();
    pulse_send(s_cyc);
    wait_done(dbase, 400, ok);
    repeat (20) @(posedge clk);
    chk_cnt++; if (got_q.size() - base !== 84) $display("FAIL busy_send_strobes: got %0d want 84", got_q.size() - base); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 84 && base + i < got_q.size(); i++) if (got_q[base + i] !== exp_b[i]) bad++;
    chk_cnt++; if (bad != 0) $display("FAIL busy_send_bytes: got %0d wrong bytes want 0", bad); else pass_cnt++;
    chk_cnt++; if (done_cnt - dbase !== 1) $display("FAIL busy_send_done: got %0d want 1", done_cnt - dbase); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL busy_send_idle: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_abort();
    int base, dbase, s_cyc;
    bit ok;
    uart_mode = 0;
    randomize_inputs();
    base = got_q.size(); dbase = done_cnt;
    pulse_send(s_cyc);
    wait_strobes(base, 10, 200, ok);
    chk_cnt++; if (!ok) $display("FAIL abort_reach10: got %0d strobes want 10", got_q.size() - base); else pass_cnt++;
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (tx_if.tx_new_byte !== 1'b0) $display("FAIL abort_strobe: got %b want 0", tx_if.tx_new_byte); else pass_cnt++;
    repeat (20) @(posedge clk);
    chk_cnt++; if (got_q.size() - base !== 10) $display("FAIL abort_strobes: got %0d want 10", got_q.size() - base); else pass_cnt++;
    chk_cnt++; if (done_cnt - dbase !== 0) $display("FAIL abort_done: got %0d want 0", done_cnt - dbase); else pass_cnt++;
    randomize_inputs();
    build_exp(target, data3, data2, data1);
    base = got_q.size(); dbase = done_cnt;
    pulse_send(s_cyc);
    wait_done(dbase, 400, ok);
    chk_cnt++; if (got_q.size() - base !== 84) $display("FAIL abort_restart_strobes: got %0d want 84", got_q.size() - base); else pass_cnt++;
    chk_cnt++; if (got_q.size() > base && got_q[base] !== target[31:24]) $display("FAIL abort_restart_first: got %h want %h", got_q[base], target[31:24]); else if (got_q.size() > base) pass_cnt++;
  endtask

  task automatic test_reset_mid_hold();
    int base, dbase, s_cyc, bad;
    bit ok, hit;
    uart_mode = 0;
    randomize_inputs();
    base = got_q.size();
    pulse_send(s_cyc);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (tx_if.tx_new_byte === 1'b1 && got_q.size() - base >= 4) hit = 1'b1;
    end
    chk_cnt++; if (!hit) $display("FAIL rst_reach_hold: got no strobe want strobe"); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (tx_if.tx_new_byte !== 1'b0) $display("FAIL rst_async_strobe: got %b want 0", tx_if.tx_new_byte); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL rst_async_done: got %b want 0", done); else pass_cnt++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    base = got_q.size(); dbase = done_cnt;
    repeat (30) @(posedge clk);
    chk_cnt++; if (got_q.size() - base !== 0) $display("FAIL rst_quiet_strobes: got %0d want 0", got_q.size() - base); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_quiet_busy: got %b want 0", busy); else pass_cnt++;
    randomize_inputs();
    build_exp(target, data3, data2, data1);
    pulse_send(s_cyc);
    wait_done(dbase, 400, ok);
    chk_cnt++; if (got_q.size() - base !== 84) $display("FAIL rst_restart_strobes: got %0d want 84", got_q.size() - base); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 84 && base + i < got_q.size(); i++) if (got_q[base + i] !== exp_b[i]) bad++;
    chk_cnt++; if (bad != 0) $display("FAIL rst_restart_bytes: got %0d wrong bytes want 0", bad); else pass_cnt++;
  endtask

  initial begin
    send   = 1'b0;
    abort  = 1'b0;
    target = '0;
    data3  = '0;
    data2  = '0;
    data1  = '0;
    test_reset();
    test_full_packet();
    test_ready_high();
    test_send_while_busy();
    test_abort();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
